// File: rtl/bch_syndrome_stream_pkg.sv
// Shared definitions for the streaming BCH/cyclic syndrome generator:
// generator polynomial constants, FSM state type, ceil-division helper
// and the single-bit polynomial division step.
package bch_pkg;

    // Widest remainder the division step can handle; P must not exceed this.
    localparam int MAX_P = 32;

    // Generator polynomials, MSB is the x^P term.
    // BCH(63,56) = (x+1)(x^6+x+1), BCH(63,57) = x^6+x+1.
    localparam logic [7:0] GEN_BCH_63_56 = 8'hC5;
    localparam logic [6:0] GEN_BCH_63_57 = 7'h43;

    // ACCUM takes beats; HOLD presents the finished syndrome.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Number of DW-bit beats needed to carry an N-bit codeword.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // One step of long division by g(x): shift the next received
    // coefficient in and subtract g(x) whenever the x^p term appears.
    function automatic logic [MAX_P-1:0] rem_step(
        input logic [MAX_P-1:0] rem,
        input logic             din,
        input logic [MAX_P:0]   poly,
        input int               p
    );
        logic [MAX_P:0] t;
        logic [MAX_P:0] mask;
        logic [5:0]     top;
        top  = p[5:0];
        t    = {rem, din};
        if (t[top]) begin
            t = t ^ poly;
        end
        mask = ((MAX_P+1)'(1) << top) - (MAX_P+1)'(1);
        t    = t & mask;
        return t[MAX_P-1:0];
    endfunction

endpackage

// File: rtl/bch_syndrome_stream_if.sv
// Stream bundle for the syndrome generator: the codeword input handshake
// and the syndrome result handshake. The master side feeds codewords and
// consumes results; the slave side is the syndrome generator.
interface bch_syndrome_stream_if #(
    parameter int DW = 1,
    parameter int P  = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          syn_valid;
    logic          syn_ready;
    logic [P-1:0]  syndrome;
    logic          syn_zero;
    logic          syn_parity;
    logic          syn_frame_err;

    modport master (
        output in_valid, in_data, in_last, syn_ready,
        input  in_ready, syn_valid, syndrome, syn_zero, syn_parity, syn_frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, syn_ready,
        output in_ready, syn_valid, syndrome, syn_zero, syn_parity, syn_frame_err
    );

endinterface

// File: rtl/bch_rem_unroll.sv
// Combinational remainder update for one beat: DW division steps unrolled,
// highest-order bit of the beat (bit DW-1) applied first.
module bch_rem_unroll
    import bch_pkg::*;
#(
    parameter int         P        = 7,
    parameter int         DW       = 1,
    parameter logic [P:0] GEN_POLY = GEN_BCH_63_56
) (
    input  logic [P-1:0]  rem_in,
    input  logic [DW-1:0] data_in,
    output logic [P-1:0]  rem_out
);

    logic [MAX_P-1:0] acc;

    // Chain DW single-bit division steps starting from the stored remainder.
    always_comb begin
        acc = MAX_P'(rem_in);
        for (int i = DW - 1; i >= 0; i--) begin
            acc = rem_step(acc, data_in[i], (MAX_P+1)'(GEN_POLY), P);
        end
        rem_out = acc[P-1:0];
    end

endmodule

// File: rtl/bch_syndrome_stream.sv
// Streaming syndrome generator: divides a received codeword, DW bits per
// beat, by g(x) and holds the P-bit remainder with zero/parity/framing
// flags until the consumer takes it.
module bch_syndrome_stream
    import bch_pkg::*;
#(
    parameter int         N        = 63,
    parameter int         P        = 7,
    parameter logic [P:0] GEN_POLY = GEN_BCH_63_56,
    parameter int         DW       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    bch_syndrome_stream_if.slave  bus
);

    localparam int                BEATS    = ceil_div(N, DW);
    localparam int                CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

    state_t           state;
    state_t           state_next;
    logic [P-1:0]     rem_q;
    logic [P-1:0]     rem_next;
    logic [P-1:0]     syndrome_q;
    logic [CNT_W-1:0] cnt_q;
    logic             frame_err_q;
    logic             accept;
    logic             final_beat;
    logic             in_ready_c;
    logic             syn_valid_c;

    bch_rem_unroll #(
        .P        (P),
        .DW       (DW),
        .GEN_POLY (GEN_POLY)
    ) u_rem_unroll (
        .rem_in  (rem_q),
        .data_in (bus.in_data),
        .rem_out (rem_next)
    );

    // Next-state and handshake decode; the last beat is whichever comes first
    // of the sender's in_last or the beat count reaching its end.
    always_comb begin
        in_ready_c  = (state == ACCUM);
        syn_valid_c = (state == HOLD);
        accept      = bus.in_valid & in_ready_c;
        final_beat  = accept & ((cnt_q == LAST_CNT) | bus.in_last);
        state_next  = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM: if (final_beat)    state_next = HOLD;
                HOLD:  if (bus.syn_ready) state_next = ACCUM;
                default:                  state_next = ACCUM;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Remainder, beat counter and held result; clear beats everything and
    // drops any beat offered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            cnt_q       <= '0;
            syndrome_q  <= '0;
            frame_err_q <= 1'b0;
        end else if (clear) begin
            rem_q       <= '0;
            cnt_q       <= '0;
            syndrome_q  <= '0;
            frame_err_q <= 1'b0;
        end else if (state == HOLD) begin
            if (bus.syn_ready) begin
                rem_q <= '0;
                cnt_q <= '0;
            end
        end else if (final_beat) begin
            rem_q       <= rem_next;
            syndrome_q  <= rem_next;
            frame_err_q <= (cnt_q != LAST_CNT) | ~bus.in_last;
        end else if (accept) begin
            rem_q <= rem_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.syn_valid     = syn_valid_c;
    assign bus.syndrome      = syndrome_q;
    assign bus.syn_zero      = ~|syndrome_q;
    assign bus.syn_parity    = ^syndrome_q;
    assign bus.syn_frame_err = frame_err_q;

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Directed bench for bch_syndrome_stream: a bit-serial instance (DW=1) and
// a byte-wide instance (DW=8) of the BCH(63,56) syndrome generator, with
// syndromes worked out by hand from g(x) = x^7+x^6+x^2+1.
module tb_bch_syndrome_stream;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clear     = 1'b0;
    logic syn_ready = 1'b0;
    logic use_wide  = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;
    int beats;

    bch_syndrome_stream_if #(.DW(1), .P(7)) bus1 ();
    bch_syndrome_stream_if #(.DW(8), .P(7)) bus8 ();

    assign bus1.syn_ready = syn_ready;
    assign bus8.syn_ready = syn_ready;

    bch_syndrome_stream #(.N(63), .P(7), .GEN_POLY(8'hC5), .DW(1)) dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus1)
    );

    bch_syndrome_stream #(.N(63), .P(7), .GEN_POLY(8'hC5), .DW(8)) dut_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    // Observed outputs of whichever instance is under test.
    logic       obs_in_ready;
    logic       obs_syn_valid;
    logic [6:0] obs_syn;
    logic       obs_zero;
    logic       obs_par;
    logic       obs_ferr;

    assign obs_in_ready  = use_wide ? bus8.in_ready      : bus1.in_ready;
    assign obs_syn_valid = use_wide ? bus8.syn_valid     : bus1.syn_valid;
    assign obs_syn       = use_wide ? bus8.syndrome      : bus1.syndrome;
    assign obs_zero      = use_wide ? bus8.syn_zero      : bus1.syn_zero;
    assign obs_par       = use_wide ? bus8.syn_parity    : bus1.syn_parity;
    assign obs_ferr      = use_wide ? bus8.syn_frame_err : bus1.syn_frame_err;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Feed a 63-bit word one bit per beat, x^62 first; in_last on beat
    // number last_at (1-based, 0 = never). Returns at the negedge where the
    // result should first be visible, with the count of beats driven.
    task automatic applyStimulus(input logic [62:0] word, input int last_at, output int sent);
        bit done = 1'b0;
        sent = 0;
        for (int b = 0; b < 63 && !done; b++) begin
            @(negedge clk);
            if (bus1.syn_valid) begin
                done = 1'b1;
            end else begin
                bus1.in_valid = 1'b1;
                bus1.in_data  = word[62-b];
                bus1.in_last  = (b + 1 == last_at);
                sent++;
            end
        end
        if (!done) @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        bus1.in_data  = '0;
    endtask

    // Feed a 64-bit padded word eight bits per beat, with up to max_gap idle
    // cycles of garbage data before each beat; in_last on the eighth beat.
    task automatic applyStimulusWide(input logic [63:0] word, input int max_gap, output int sent);
        bit done = 1'b0;
        int gap;
        sent = 0;
        for (int b = 0; b < 8 && !done; b++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                bus8.in_valid = 1'b0;
                bus8.in_last  = 1'b1;
                bus8.in_data  = 8'($urandom);
            end
            @(negedge clk);
            if (bus8.syn_valid) begin
                done = 1'b1;
            end else begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = word[63-8*b -: 8];
                bus8.in_last  = (b == 7);
                sent++;
            end
        end
        if (!done) @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        bus8.in_data  = '0;
    endtask

    // Check a held result, keep it waiting hold_cycles, then release it.
    task automatic collectResult(input string tag, input int exp_beats, input int sent,
                                 input logic [6:0] exp_syn, input logic exp_ferr, input int hold_cycles);
        checkOutput({tag, "_beats"},  sent, exp_beats);
        checkOutput({tag, "_valid"},  obs_syn_valid, 1);
        checkOutput({tag, "_syn"},    obs_syn, exp_syn);
        checkOutput({tag, "_zero"},   obs_zero, (exp_syn == 7'h00));
        checkOutput({tag, "_parity"}, obs_par, ^exp_syn);
        checkOutput({tag, "_ferr"},   obs_ferr, exp_ferr);
        repeat (hold_cycles) begin
            @(negedge clk);
            checkOutput({tag, "_hold_ready"}, obs_in_ready, 0);
            checkOutput({tag, "_hold_valid"}, obs_syn_valid, 1);
            checkOutput({tag, "_hold_syn"},   obs_syn, exp_syn);
        end
        syn_ready = 1'b1;
        checkOutput({tag, "_release_ready"}, obs_in_ready, 0);
        @(negedge clk);
        syn_ready = 1'b0;
        checkOutput({tag, "_after_valid"}, obs_syn_valid, 0);
        checkOutput({tag, "_after_ready"}, obs_in_ready, 1);
    endtask

    // Safety net so the run always ends even if the design stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_ready",  obs_in_ready, 1);
        checkOutput("reset_valid",  obs_syn_valid, 0);
        checkOutput("reset_syn",    obs_syn, 7'h00);
        checkOutput("reset_zero",   obs_zero, 1);
        checkOutput("reset_parity", obs_par, 0);
        checkOutput("reset_ferr",   obs_ferr, 0);
        checkOutput("reset_wide_ready", bus8.in_ready, 1);
        rst_n = 1'b1;

        applyStimulus(63'h0, 63, beats);
        collectResult("zero_word", 63, beats, 7'h00, 1'b0, 0);
        applyStimulus(63'h1, 63, beats);
        collectResult("x0", 63, beats, 7'h01, 1'b0, 0);
        applyStimulus(63'h80, 63, beats);
        collectResult("x7", 63, beats, 7'h45, 1'b0, 2);

        use_wide = 1'b1;
        applyStimulusWide(64'hC5, 0, beats);
        collectResult("wide_g", 8, beats, 7'h00, 1'b0, 0);
        applyStimulusWide(64'hC4, 0, beats);
        collectResult("wide_g_flip", 8, beats, 7'h01, 1'b0, 0);
        applyStimulusWide(64'h100, 0, beats);
        collectResult("wide_x8", 8, beats, 7'h4F, 1'b0, 0);
        applyStimulusWide(64'hC500, 0, beats);
        collectResult("wide_g_x8", 8, beats, 7'h00, 1'b0, 0);
        applyStimulusWide(64'hC5, 3, beats);
        collectResult("wide_g_gaps", 8, beats, 7'h00, 1'b0, 5);
        applyStimulusWide(64'hC4, 3, beats);
        collectResult("wide_flip_gaps", 8, beats, 7'h01, 1'b0, 5);
        use_wide = 1'b0;

        applyStimulus(63'h1000_0000_0000_0000, 10, beats);
        collectResult("early_last", 10, beats, 7'h45, 1'b1, 0);
        applyStimulus(63'h1, 0, beats);
        collectResult("no_last", 63, beats, 7'h01, 1'b1, 0);

        for (int b = 0; b < 29; b++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.in_data  = 1'(b % 2);
            bus1.in_last  = 1'b0;
        end
        @(negedge clk);
        clear = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 1'b1;
        bus1.in_last  = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        bus1.in_data  = '0;
        checkOutput("clear_valid", obs_syn_valid, 0);
        checkOutput("clear_ready", obs_in_ready, 1);
        applyStimulus(63'hC5, 63, beats);
        collectResult("after_clear", 63, beats, 7'h00, 1'b0, 0);

        applyStimulus(63'h80, 63, beats);
        checkOutput("pre_reset_valid", obs_syn_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", obs_syn_valid, 0);
        checkOutput("async_reset_ready", obs_in_ready, 1);
        checkOutput("async_reset_syn",   obs_syn, 7'h00);
        checkOutput("async_reset_zero",  obs_zero, 1);
        checkOutput("async_reset_ferr",  obs_ferr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(63'h401, 63, beats);
        collectResult("b2b_x10_x0", 63, beats, 7'h72, 1'b0, 0);
        applyStimulus(63'h200, 63, beats);
        collectResult("b2b_x9", 63, beats, 7'h5B, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
